// File: rtl/disp_arb_pkg.sv
// Shared definitions for the display frame-buffer arbiter:
// controller state encoding and default bus widths.
package disp_arb_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ADDR_W = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/disp_prefetch_fifo.sv
// Show-ahead prefetch FIFO: head is visible while not empty, pop advances,
// flush empties it in one cycle and overrides any push or pop.
module disp_prefetch_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_push;
    logic              do_pop;

    assign empty   = (level_q == '0);
    assign do_push = push && !flush && (level_q != LVL_W'(DEPTH));
    assign do_pop  = pop && !flush && !empty;
    assign head    = mem_q[rptr_q];
    assign level   = level_q;

    // Next pointer and level values; a flush returns everything to empty.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            if (do_push && !do_pop)      level_d = level_q + 1'b1;
            else if (do_pop && !do_push) level_d = level_q - 1'b1;
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/disp_fb_arbiter.sv
// Frame-buffer arbiter: prefetches pixels for a display driver and shares
// the memory port with a writer. Reads are urgent while the prefetch FIFO
// runs low; otherwise writes take priority over refill reads.
// Optional feature macro DISP_ARB_TEARFREE_EN: when defined, writes are only
// granted outside FETCH so the frame being scanned out never changes.
module disp_fb_arbiter
    import disp_arb_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned H_ACT      = 800,
    parameter int unsigned V_ACT      = 480,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned WR_THRESH  = 4
) (
    input  logic              ClkDisp,
    input  logic              Rst_n,
    input  logic              DataReq,
    input  logic              Frame_Begin,
    output logic [DATA_W-1:0] Data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              underflow
);

    localparam int unsigned       LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_ACT * V_ACT - 1);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              inflight_q, inflight_d;
    logic              underflow_q, underflow_d;

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_push;
    logic              fifo_pop;
    logic              rd_kill;

    logic [LVL_W:0]    fill;
    logic              can_rd;
    logic              urgent;
    logic              wr_allow;
    logic              wr_grant;
    logic              rd_issue;
    logic              run;

    // Grants are suppressed while reset is held so the memory bus stays quiet.
    assign run = !Rst_n;

    // A read returning in the Frame_Begin cycle belongs to the old frame.
    assign rd_kill   = Frame_Begin && inflight_q;
    assign fifo_push = inflight_q && !rd_kill;
    assign fifo_pop  = DataReq && !fifo_empty && !Frame_Begin;
    assign Data      = fifo_empty ? '0 : fifo_head;

    disp_prefetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ClkDisp),
        .rst   (Rst_n),
        .flush (Frame_Begin),
        .push  (fifo_push),
        .din   (mem_rdata),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef DISP_ARB_TEARFREE_EN
    assign wr_allow = (state_q != FETCH);
`else
    assign wr_allow = 1'b1;
`endif

    // Slot arbitration: urgent read, then write, then refill read.
    always_comb begin
        fill     = {1'b0, fifo_level} + (LVL_W + 1)'(inflight_q);
        can_rd   = run && (state_q == FETCH) && !Frame_Begin
                   && (fill < (LVL_W + 1)'(FIFO_DEPTH));
        urgent   = can_rd && (fill < (LVL_W + 1)'(WR_THRESH));
        wr_grant = run && wr_valid && wr_allow && !urgent;
        rd_issue = can_rd && !wr_grant;
    end

    // Memory port drive for the granted slot.
    always_comb begin
        wr_ready  = wr_grant;
        mem_en    = wr_grant || rd_issue;
        mem_we    = wr_grant;
        mem_addr  = '0;
        mem_wdata = '0;
        if (wr_grant) begin
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end else if (rd_issue) begin
            mem_addr  = rd_ptr_q;
        end
    end

    // Next-state logic; Frame_Begin restarts the frame from any state.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        inflight_d  = rd_issue;
        underflow_d = underflow_q;
        if (rd_issue) begin
            if (rd_ptr_q == LAST_PIX) state_d  = DONE;
            else                      rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (DataReq && fifo_empty) underflow_d = 1'b1;
        if (Frame_Begin) begin
            state_d     = FETCH;
            rd_ptr_d    = '0;
            underflow_d = 1'b0;
        end
    end

    // Controller state register.
    always_ff @(posedge ClkDisp or posedge Rst_n) begin
        if (Rst_n) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            inflight_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            inflight_q  <= inflight_d;
            underflow_q <= underflow_d;
        end
    end

    assign underflow = underflow_q;

endmodule

// File: tb/tb_disp_fb_arbiter.sv
// Directed bench for disp_fb_arbiter with a pixel scoreboard and a
// one-cycle-latency memory model.
module tb_disp_fb_arbiter;

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 19;
    localparam int unsigned HA   = 16;
    localparam int unsigned VA   = 8;
    localparam int unsigned LAST = HA * VA - 1;
`ifdef DISP_ARB_TEARFREE_EN
    localparam bit TF = 1'b1;
`else
    localparam bit TF = 1'b0;
`endif

    logic          ClkDisp;
    logic          Rst_n;
    logic          DataReq;
    logic          Frame_Begin;
    logic [DW-1:0] Data;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          underflow;

    disp_fb_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .H_ACT      (HA),
        .V_ACT      (VA),
        .FIFO_DEPTH (8),
        .WR_THRESH  (4)
    ) dut (
        .ClkDisp     (ClkDisp),
        .Rst_n       (Rst_n),
        .DataReq     (DataReq),
        .Frame_Begin (Frame_Begin),
        .Data        (Data),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .underflow   (underflow)
    );

    initial ClkDisp = 1'b0;
    always #5 ClkDisp = ~ClkDisp;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {a[7:0] ^ 8'h3C, a[7:0]};
    endfunction

    // Memory: read data one cycle after the strobe, noise otherwise.
    always @(posedge ClkDisp) begin
        if (mem_en && !mem_we) mem_rdata <= pat(mem_addr);
        else                   mem_rdata <= DW'($urandom);
    end

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state of the prefetch path.
    logic [DW-1:0] sb_q[$];
    bit            m_fetch;
    bit            m_infl;
    bit            m_uf;
    int unsigned   m_rdptr;
    int unsigned   m_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_fetch = 1'b0;
        m_infl  = 1'b0;
        m_uf    = 1'b0;
        m_rdptr = 0;
        m_ret   = 0;
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model.
    task automatic cyc(input bit rst, input bit fb, input bit dr, input bit wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        int fill;
        bit can_rd, urgent, e_wr, e_rd;
        Rst_n = rst; Frame_Begin = fb; DataReq = dr;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        #1;
        if (rst) begin
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_underflow", underflow, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_Data", Data, 0);
            model_reset();
        end else begin
            fill   = sb_q.size() + int'(m_infl);
            can_rd = m_fetch && !fb && (fill < 8);
            urgent = can_rd && (fill < 4);
            e_wr   = wv && !urgent && (!TF || !m_fetch);
            e_rd   = can_rd && !e_wr;
            chk("wr_ready", wr_ready, e_wr);
            chk("mem_en", mem_en, e_wr || e_rd);
            if (e_wr || e_rd) chk("mem_we", mem_we, e_wr);
            if (e_wr) begin
                chk("wr_addr", mem_addr, wa);
                chk("wr_wdata", mem_wdata, wd);
            end
            if (e_rd) chk("rd_addr", mem_addr, m_rdptr);
            chk("Data", Data, (sb_q.size() != 0) ? sb_q[0] : '0);
            chk("underflow", underflow, m_uf);
            if (dr && !fb) begin
                if (sb_q.size() != 0) void'(sb_q.pop_front());
                else                  m_uf = 1'b1;
            end
            if (m_infl && !fb) sb_q.push_back(pat(AW'(m_ret)));
            m_infl = e_rd;
            if (e_rd) begin
                m_ret = m_rdptr;
                if (m_rdptr == LAST) m_fetch = 1'b0;
                else                 m_rdptr++;
            end
            if (fb) begin
                sb_q.delete();
                m_uf    = 1'b0;
                m_rdptr = 0;
                m_fetch = 1'b1;
            end
        end
        @(negedge ClkDisp);
    endtask

    initial begin
        Rst_n = 1'b1; Frame_Begin = 1'b0; DataReq = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        @(negedge ClkDisp);

        // Reset held with busy inputs: everything quiet.
        repeat (3) cyc(1, 0, 1, 1, 19'h1234, 16'hBEEF);

        // IDLE: writes granted, no reads.
        cyc(0, 0, 0, 1, 19'h00010, 16'h1111);
        cyc(0, 0, 0, 1, 19'h7FFFF, 16'hFFFF);
        cyc(0, 0, 0, 0, '0, '0);

        // Frame start, no pops: reads 0..7 then FIFO full and idle.
        cyc(0, 1, 0, 0, '0, '0);
        repeat (12) cyc(0, 0, 0, 0, '0, '0);

        // Writer active while full: writes every cycle.
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 1, AW'($urandom), DW'($urandom));

        // Pop down with writer active: urgent read wins once low.
        for (int i = 0; i < 8; i++)
            cyc(0, 0, 1, 1, AW'($urandom), DW'($urandom));
        repeat (10) cyc(0, 0, 0, 0, '0, '0);

        // Stream until address 100 is in flight.
        for (int i = 0; i < 300 && !(m_infl && m_ret == 100); i++)
            cyc(0, 0, 1, 0, '0, '0);
        chk("reach_rd100", m_infl && m_ret == 100, 1);

        // Frame_Begin with pop and write together; returning read is dropped.
        cyc(0, 1, 1, 1, 19'h00ABC, 16'h5555);
        // Empty FIFO pop: Data 0, underflow set and held.
        cyc(0, 0, 1, 0, '0, '0);
        repeat (6) cyc(0, 0, 0, 0, '0, '0);

        // Run the frame to its end with a random writer, draining past empty.
        for (int i = 0; i < 200; i++)
            cyc(0, 0, 1, 1'($urandom), AW'($urandom), DW'($urandom));
        repeat (4) cyc(0, 0, 0, 1, AW'($urandom), DW'($urandom));

        // New frame clears underflow; then reset mid-frame.
        cyc(0, 1, 0, 0, '0, '0);
        repeat (5) cyc(0, 0, 0, 0, '0, '0);
        cyc(1, 0, 0, 0, '0, '0);
        repeat (3) cyc(0, 0, 0, 0, '0, '0);

        // Restart after reset: reads from 0 again.
        cyc(0, 1, 0, 0, '0, '0);
        for (int i = 0; i < 20; i++)
            cyc(0, 0, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
